// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and constants for the OCI compressed-trace (DCT) frame sequencer.
package nios2_oci_dct_pkg;

    localparam int unsigned ATOM_W = 2;
    localparam int unsigned SLOTS  = 15;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUF_W  = ATOM_W * SLOTS;

    typedef struct packed {
        logic             ovf;
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] data;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } dct_state_e;

    localparam int unsigned CAUSE_W = 3;
    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_FULL    = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_FLUSH   = 3'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_TRC_OFF = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_RETRY   = 3'd5;

endpackage

// File: rtl/nios2_oci_dct_hold.sv
// Single-entry valid/ready holding register presenting one closed frame to trace RAM.
module nios2_oci_dct_hold
    import nios2_oci_dct_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  frame_t load_frame,
    input  logic   out_ready,
    output logic   out_valid,
    output frame_t out_frame,
    output logic   free_c
);

    // Holding can take a new frame when empty or when its frame leaves this cycle.
    assign free_c = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_frame <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_frame <= load_frame;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// DCT sequencer: packs trace atoms into frames, closes them on full/flush/trace-off/timeout,
// and hands them to the holding register; drops atoms (sticky overflow) while stalled.
module nios2_oci_dct_ctrl
    import nios2_oci_dct_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trc_on,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    input  logic              flush_req,
    input  logic              ovf_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              ovf_status
);

    localparam int unsigned TMR_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(FLUSH_TIMEOUT);

    dct_state_e         state;
    logic               trc_on_q;
    logic               ovf_pend;
    logic               close_pend;
    logic [TMR_W-1:0]   idle_timer;

    logic               accept;
    logic               drop;
    logic               hold_free_c;
    logic               do_close;
    logic               go_stall;
    logic               timeout_hit;
    logic [CNT_W-1:0]   n_post;
    logic [BUF_W-1:0]   buf_post;
    logic [TMR_W-1:0]   timer_inc;
    logic [CAUSE_W-1:0] close_cause;
    frame_t             load_frame;
    frame_t             hold_frame;

    // Post-accept view of the accumulator and the close decision for this cycle.
    always_comb begin
        accept   = atom_valid && trc_on && (state != STALL);
        drop     = atom_valid && trc_on && (state == STALL);
        n_post   = dct_count + CNT_W'(accept);
        buf_post = dct_buffer;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (accept && (dct_count == CNT_W'(k))) begin
                buf_post[k*ATOM_W +: ATOM_W] = atom_data;
            end
        end

        // The timeout fires on the idle cycle that brings the idle count to FLUSH_TIMEOUT.
        timer_inc   = (idle_timer == TMR_LIMIT) ? idle_timer : idle_timer + TMR_W'(1);
        timeout_hit = (FLUSH_TIMEOUT != 0) && !accept && (dct_count != '0) &&
                      (timer_inc == TMR_LIMIT);

        close_cause = CAUSE_NONE;
        if (n_post == CNT_W'(SLOTS)) begin
            close_cause = CAUSE_FULL;
        end else if (n_post != '0) begin
            if (flush_req) begin
                close_cause = CAUSE_FLUSH;
            end else if (trc_on_q && !trc_on) begin
                close_cause = CAUSE_TRC_OFF;
            end else if (timeout_hit) begin
                close_cause = CAUSE_TIMEOUT;
            end else if (close_pend) begin
                close_cause = CAUSE_RETRY;
            end
        end

        do_close   = (close_cause != CAUSE_NONE) && hold_free_c;
        go_stall   = (close_cause == CAUSE_FULL) && !hold_free_c;
        load_frame = '{ovf: ovf_pend, count: n_post, data: buf_post};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trc_on_q   <= 1'b0;
            ovf_pend   <= 1'b0;
            close_pend <= 1'b0;
            idle_timer <= '0;
            dct_buffer <= '0;
            dct_count  <= '0;
            ovf_status <= 1'b0;
        end else begin
            trc_on_q <= trc_on;

            if (do_close) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (accept) begin
                dct_buffer <= buf_post;
                dct_count  <= n_post;
            end

            if (do_close || accept || (n_post == '0)) begin
                idle_timer <= '0;
            end else begin
                idle_timer <= timer_inc;
            end

            // A close that could not be delivered keeps retrying until holding frees.
            close_pend <= (close_cause != CAUSE_NONE) && !hold_free_c;

            // A drop in the same cycle as a load belongs to the following frame.
            if (drop) begin
                ovf_pend <= 1'b1;
            end else if (do_close) begin
                ovf_pend <= 1'b0;
            end

            if (drop) begin
                ovf_status <= 1'b1;
            end else if (ovf_clear) begin
                ovf_status <= 1'b0;
            end

            if (do_close) begin
                state <= IDLE;
            end else if (go_stall || (state == STALL)) begin
                state <= STALL;
            end else if (n_post != '0) begin
                state <= FILL;
            end else begin
                state <= IDLE;
            end
        end
    end

    nios2_oci_dct_hold u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (do_close),
        .load_frame (load_frame),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_frame  (hold_frame),
        .free_c     (hold_free_c)
    );

    assign out_data  = hold_frame.data;
    assign out_count = hold_frame.count;
    assign out_ovf   = hold_frame.ovf;

endmodule

// File: tb/tb_nios2_oci_dct_ctrl.sv
// Self-checking bench for nios2_oci_dct_ctrl: vector table plus multi-cycle corner sequences,
// with delivered frames checked against a scoreboard queue.
module tb_nios2_oci_dct_ctrl;
    import nios2_oci_dct_pkg::*;

    localparam int M_FULL       = 0;
    localparam int M_FLUSH      = 1;
    localparam int M_FLUSH_LAST = 2;
    localparam int M_TRCOFF     = 3;
    localparam int NVEC         = 8;

    typedef struct {
        int               n_atoms;
        int               a0;
        int               inc;
        int               mode;
        logic [CNT_W-1:0] exp_count;
        logic [BUF_W-1:0] exp_data;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              trc_on;
    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;
    logic              flush_req;
    logic              ovf_clear;
    logic              out_valid;
    logic              out_ready;
    logic [BUF_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              ovf_status;

    int     checks = 0;
    int     passed = 0;
    int     frames_seen = 0;
    frame_t sb[$];
    vec_t   vecs[NVEC];

    nios2_oci_dct_ctrl #(.FLUSH_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .trc_on     (trc_on),
        .atom_valid (atom_valid),
        .atom_data  (atom_data),
        .flush_req  (flush_req),
        .ovf_clear  (ovf_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .ovf_status (ovf_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic ovf, input logic [CNT_W-1:0] cnt,
                              input logic [BUF_W-1:0] data);
        frame_t f;
        f.ovf   = ovf;
        f.count = cnt;
        f.data  = data;
        sb.push_back(f);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_queue", 64'(sb.size()), 64'd0);
    endtask

    // Frame monitor: every transfer must match the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            frames_seen++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_frame: got count=%0d data=0x%0h, no frame expected",
                         out_count, out_data);
            end else begin
                frame_t e;
                e = sb.pop_front();
                check("frame", 64'({out_ovf, out_count, out_data}), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;

        vecs[0] = '{15, 0, 1, M_FULL,       4'd15, 30'h24E4E4E4};
        vecs[1] = '{3,  3, 3, M_FLUSH,      4'd3,  30'h0000001B};
        vecs[2] = '{0,  0, 0, M_FLUSH,      4'd0,  30'h00000000};
        vecs[3] = '{7,  2, 0, M_TRCOFF,     4'd7,  30'h00002AAA};
        vecs[4] = '{1,  1, 0, M_FLUSH,      4'd1,  30'h00000001};
        vecs[5] = '{14, 3, 0, M_FLUSH,      4'd14, 30'h0FFFFFFF};
        vecs[6] = '{15, 1, 0, M_FULL,       4'd15, 30'h15555555};
        vecs[7] = '{2,  2, 1, M_FLUSH_LAST, 4'd2,  30'h0000000E};

        reset      = 1'b1;
        trc_on     = 1'b1;
        atom_valid = 1'b0;
        atom_data  = '0;
        flush_req  = 1'b0;
        ovf_clear  = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_out", 64'({out_valid, out_ovf, out_count, out_data}), 64'd0);
        check("reset_dct", 64'({dct_count, dct_buffer}), 64'd0);
        check("reset_ovf_status", 64'(ovf_status), 64'd0);

        // Table-driven frames with out_ready held high.
        for (int v = 0; v < NVEC; v++) begin
            seen0 = frames_seen;
            if (vecs[v].exp_count != '0) push_frame(1'b0, vecs[v].exp_count, vecs[v].exp_data);
            for (int k = 0; k < vecs[v].n_atoms; k++) begin
                atom_valid = 1'b1;
                atom_data  = 2'(vecs[v].a0 + k * vecs[v].inc);
                flush_req  = (vecs[v].mode == M_FLUSH_LAST) && (k == vecs[v].n_atoms - 1);
                step();
            end
            atom_valid = 1'b0;
            flush_req  = 1'b0;
            if (vecs[v].mode == M_FLUSH) begin
                flush_req = 1'b1;
                step();
                flush_req = 1'b0;
            end else if (vecs[v].mode == M_TRCOFF) begin
                trc_on     = 1'b0;
                atom_valid = 1'b1;
                atom_data  = 2'd3;
                step();
                step();
                atom_valid = 1'b0;
                trc_on     = 1'b1;
            end
            wait_drain();
            check($sformatf("vec%0d_frames", v), 64'(frames_seen - seen0),
                  (vecs[v].exp_count != '0) ? 64'd1 : 64'd0);
            check($sformatf("vec%0d_dct_count", v), 64'(dct_count), 64'd0);
        end

        // Idle timeout: two atoms, then the frame appears on the 64th idle cycle.
        push_frame(1'b0, 4'd2, 30'h9);
        atom_valid = 1'b1;
        atom_data  = 2'd1;
        step();
        atom_data  = 2'd2;
        step();
        atom_valid = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 63) check("timeout_early", 64'(out_valid), 64'd0);
            if (i == 64) check("timeout_fire", 64'(out_valid), 64'd1);
        end
        wait_drain();

        // Backpressure: first frame held, second fills, stall drops atoms.
        out_ready = 1'b0;
        push_frame(1'b0, 4'd15, 30'h15555555);
        for (int k = 0; k < 15; k++) begin
            atom_valid = 1'b1;
            atom_data  = 2'd1;
            if (k == 14) check("latency_before", 64'(out_valid), 64'd0);
            step();
        end
        check("latency_after", 64'(out_valid), 64'd1);
        check("full_clears_count", 64'(dct_count), 64'd0);
        push_frame(1'b1, 4'd15, 30'h3FFFFFFF);
        for (int k = 0; k < 15; k++) begin
            atom_data = 2'd3;
            step();
        end
        check("stall_count", 64'(dct_count), 64'd15);
        check("ovf_before_drop", 64'(ovf_status), 64'd0);
        for (int k = 0; k < 4; k++) begin
            atom_data = 2'd0;
            ovf_clear = (k == 3);
            step();
        end
        atom_valid = 1'b0;
        ovf_clear  = 1'b0;
        check("ovf_set_wins", 64'(ovf_status), 64'd1);
        check("stall_buffer_kept", 64'({dct_count, dct_buffer}), 64'({4'd15, 30'h3FFFFFFF}));
        check("hold_stable", 64'({out_valid, out_data}), 64'({1'b1, 30'h15555555}));
        out_ready = 1'b1;
        wait_drain();
        push_frame(1'b0, 4'd2, 30'h4);
        atom_valid = 1'b1;
        atom_data  = 2'd0;
        step();
        atom_data  = 2'd1;
        step();
        atom_valid = 1'b0;
        flush_req  = 1'b1;
        step();
        flush_req  = 1'b0;
        wait_drain();
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_cleared", 64'(ovf_status), 64'd0);

        // Reset with a held frame and a partial frame: everything discarded.
        out_ready  = 1'b0;
        atom_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            atom_data = (k < 15) ? 2'd2 : 2'd1;
            step();
        end
        atom_valid = 1'b0;
        check("pre_reset_state", 64'({out_valid, dct_count}), 64'({1'b1, 4'd9}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", 64'({out_valid, out_ovf, out_count, out_data}), 64'd0);
        check("async_reset_dct", 64'({ovf_status, dct_count, dct_buffer}), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        seen0 = frames_seen;
        repeat (80) step();
        check("post_reset_no_frame", 64'(frames_seen - seen0), 64'd0);
        check("post_reset_count", 64'(dct_count), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
